// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: widths, defaults and helpers shared by the data-memory arbiter.
// Rev 1.0 -- initial release.
`default_nettype none

package dmem_arb_pkg;
  localparam int WORD_W           = 32;
  localparam int ADDR_W           = 32;
  localparam int WORD_SEL_LSB     = 2;
  localparam int WORD_SEL_MSB     = 4;
  localparam int MAX_REQ          = 4;
  localparam int DEFAULT_MAX_WAIT = 8;

  // Index of the set bit of a one-hot vector; 0 when the vector is empty.
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction
endpackage

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational one-hot grant selection for dmem_arbiter.
// DMEM_ARB_RR_EN selects round-robin from a pointer; otherwise fixed priority with starved override.
`default_nettype none

module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
`ifdef DMEM_ARB_RR_EN
  input  logic [IDX_W-1:0]   i_ptr,
`else
  input  logic [NUM_REQ-1:0] i_starved,
`endif
  output logic [NUM_REQ-1:0] o_grant
);

`ifdef DMEM_ARB_RR_EN
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_gdbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_rot_oh;

  // Rotate so the pointer port sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_dbl    = {i_valid, i_valid} >> i_ptr;
    w_rot    = w_dbl[NUM_REQ-1:0];
    w_rot_oh = w_rot & (-w_rot);
    w_gdbl   = {w_rot_oh, w_rot_oh} << i_ptr;
    o_grant  = w_gdbl[2*NUM_REQ-1:NUM_REQ];
  end
`else
  logic [NUM_REQ-1:0] w_starved_req;
  logic [NUM_REQ-1:0] w_cand;

  // Starved requesters form their own tier above everyone else.
  always_comb begin
    w_starved_req = i_valid & i_starved;
    w_cand        = (w_starved_req != '0) ? w_starved_req : i_valid;
    o_grant       = w_cand & (-w_cand);
  end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory among NUM_REQ requesters, one access per cycle.
// Define DMEM_ARB_RR_EN for round-robin; default is fixed priority with a starvation guard.
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WORD_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WORD_W-1:0]         rsp_data,
  output logic                      mem_read_enable,
  output logic                      mem_write_enable,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [WORD_W-1:0]         mem_write_data,
  input  logic [WORD_W-1:0]         mem_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic             w_any;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W-1:0] r_rsp_idx;
  logic             r_rsp_rd;

`ifdef DMEM_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + IDX_W'(1);
    end
  end

  dmem_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (req_ready)
  );
`else
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [NUM_REQ-1:0] w_starved;

  // Port 0 already has top priority and never needs the guard.
  assign w_starved[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REQ; gi++) begin : g_wait
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (!req_valid[gi] || req_ready[gi]) begin
          r_cnt <= '0;
        end else if (r_cnt != CNT_W'(MAX_WAIT)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_starved[gi] = (r_cnt == CNT_W'(MAX_WAIT));
    end
  endgenerate

  dmem_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_valid   (req_valid),
    .i_starved (w_starved),
    .o_grant   (req_ready)
  );
`endif

  assign w_any     = |req_ready;
  assign w_gnt_idx = IDX_W'(onehot_to_idx(MAX_REQ'(req_ready)));

  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    if (w_any) begin
      mem_read_enable  = ~req_we[w_gnt_idx];
      mem_write_enable = req_we[w_gnt_idx];
      mem_address      = req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
      mem_write_data   = req_wdata[int'(w_gnt_idx)*WORD_W +: WORD_W];
    end
  end

  // The memory output is registered, so read data for a grant arrives one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_rd  <= 1'b0;
      r_rsp_idx <= '0;
    end else begin
      r_rsp_rd  <= mem_read_enable;
      r_rsp_idx <= w_gnt_idx;
    end
  end

  assign rsp_valid = r_rsp_rd ? (NUM_REQ'(1) << r_rsp_idx) : '0;
  assign rsp_data  = mem_data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter model.
// Build with DMEM_ARB_RR_EN to check the round-robin variant.
`default_nettype none

module tb_dmem_arbiter;
  localparam int N    = 2;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [31:0]   rsp_data, mem_address, mem_write_data, mem_data;
  logic          mem_read_enable, mem_write_enable;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] env_mem [8];
  logic [31:0] sh [8];

  dmem_arbiter #(.NUM_REQ(N), .MAX_WAIT(MAXW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_data         (mem_data)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read output.
  always @(posedge clk) begin
    if (mem_write_enable) env_mem[mem_address[4:2]] <= mem_write_data;
    if (mem_read_enable)  mem_data <= env_mem[mem_address[4:2]];
  end

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[p]         = v;
    req_we[p]            = we;
    req_addr[p*32 +: 32] = a;
    req_wdata[p*32 +: 32] = d;
  endtask

  task automatic clear_req;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_req();
    #1;
    n_vec++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL reset_outputs: rsp_valid=%b req_ready=%b, expected 00 00", rsp_valid, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mem_read_enable, mem_write_enable, rsp_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_release: re=%b we=%b rsp_valid=%b, expected all 0",
               mem_read_enable, mem_write_enable, rsp_valid);
    end
  endtask

  task automatic test_idle;
    clear_req();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if ({mem_read_enable, mem_write_enable, req_ready, rsp_valid, mem_address, mem_write_data} !== '0) begin
        n_err++;
        $display("FAIL idle: re=%b we=%b ready=%b rsp=%b addr=%h wd=%h, expected all 0",
                 mem_read_enable, mem_write_enable, req_ready, rsp_valid, mem_address, mem_write_data);
      end
    end
  endtask

  task automatic test_single_read;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, 1'b1, 32'(k * 4), 32'(k));
      #1;
      n_vec++;
      if (req_ready !== 2'b01 || mem_write_enable !== 1'b1 || mem_address !== 32'(k * 4)) begin
        n_err++;
        $display("FAIL preload_write[%0d]: ready=%b we=%b addr=%h, expected 01 1 %h",
                 k, req_ready, mem_write_enable, mem_address, 32'(k * 4));
      end
      sh[k] = 32'(k);
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 2'b00) begin
        n_err++;
        $display("FAIL write_no_rsp[%0d]: rsp_valid=%b, expected 00", k, rsp_valid);
      end
    end
    set_req(0, 1'b1, 1'b0, 32'h0000000C, 32'h0);
    #1;
    n_vec++;
    if (req_ready !== 2'b01 || mem_read_enable !== 1'b1 || mem_address !== 32'h0000000C) begin
      n_err++;
      $display("FAIL single_read_grant: ready=%b re=%b addr=%h, expected 01 1 0000000c",
               req_ready, mem_read_enable, mem_address);
    end
    @(posedge clk); #1;
    clear_req();
    n_vec++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'h3) begin
      n_err++;
      $display("FAIL single_read_rsp: rsp_valid=%b data=%h, expected 01 00000003", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_write_read;
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b1, 32'h14, 32'hDEADBEEF);
    #1;
    n_vec++;
    if (req_ready !== 2'b10 || mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 ||
        mem_address !== 32'h14 || mem_write_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wr_drive: ready=%b we=%b re=%b addr=%h wd=%h, expected 10 1 0 00000014 deadbeef",
               req_ready, mem_write_enable, mem_read_enable, mem_address, mem_write_data);
    end
    sh[5] = 32'hDEADBEEF;
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 32'h14, 32'h0);
    #1;
    n_vec++;
    if (req_ready !== 2'b10 || mem_read_enable !== 1'b1 || rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL rd_after_wr_grant: ready=%b re=%b rsp=%b, expected 10 1 00",
               req_ready, mem_read_enable, rsp_valid);
    end
    @(posedge clk); #1;
    clear_req();
    n_vec++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL rd_after_wr_rsp: rsp_valid=%b data=%h, expected 10 deadbeef", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_contention;
    logic [N-1:0] eg;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0);
    for (int c = 0; c < 20; c++) begin
`ifdef DMEM_ARB_RR_EN
      eg = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      eg = (c % 9 == 8) ? 2'b10 : 2'b01;
`endif
      #1;
      n_vec++;
      if (req_ready !== eg) begin
        n_err++;
        $display("FAIL contention_grant[%0d]: ready=%b, expected %b", c, req_ready, eg);
      end
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== eg || rsp_data !== ((eg == 2'b10) ? sh[1] : sh[0])) begin
        n_err++;
        $display("FAIL contention_rsp[%0d]: rsp_valid=%b data=%h, expected %b %h",
                 c, rsp_valid, rsp_data, eg, (eg == 2'b10) ? sh[1] : sh[0]);
      end
    end
    clear_req();
  endtask

  task automatic test_reset_mid_read;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL mid_read_grant: ready=%b, expected 01", req_ready);
    end
    @(posedge clk); #1;
    clear_req();
    reset = 1'b1;
    #1;
    n_vec++;
    if (rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL mid_read_async_clear: rsp_valid=%b, expected 00", rsp_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    // Read presented while reset is held across the edge must never respond.
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    clear_req();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (rsp_valid !== 2'b00) begin
        n_err++;
        $display("FAIL post_reset_rsp[%0d]: rsp_valid=%b, expected 00", c, rsp_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    bit          pv  [N];
    bit          pwe [N];
    logic [31:0] pa  [N];
    logic [31:0] pd  [N];
    int          wc  [N];
    int          ptr;
    int          g;
    bit          nrv;
    int          nrp;
    logic [31:0] nrd;
    logic [N-1:0] eg;
    logic [65:0] edrv;

    @(posedge clk); #1;
    reset = 1'b1;
    clear_req();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int p = 0; p < N; p++) begin
      pv[p] = 1'b0; pwe[p] = 1'b0; pa[p] = '0; pd[p] = '0; wc[p] = 0;
    end
    ptr = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (!pv[p] && $urandom_range(0, 9) < 7) begin
          pv[p]  = 1'b1;
          pwe[p] = ($urandom_range(0, 2) == 0);
          pa[p]  = 32'($urandom_range(0, 7) * 4);
          pd[p]  = $urandom;
        end
        set_req(p, pv[p], pwe[p], pa[p], pd[p]);
      end
      #1;

      g = -1;
`ifdef DMEM_ARB_RR_EN
      for (int k = 0; k < N; k++)
        if (g < 0 && pv[(ptr + k) % N]) g = (ptr + k) % N;
`else
      for (int p = 1; p < N; p++)
        if (g < 0 && pv[p] && wc[p] >= MAXW) g = p;
      for (int p = 0; p < N; p++)
        if (g < 0 && pv[p]) g = p;
`endif
      eg   = (g < 0) ? '0 : (N'(1) << g);
      edrv = (g < 0) ? '0 : {~pwe[g], pwe[g], pa[g], pd[g]};

      n_vec++;
      if (req_ready !== eg) begin
        n_err++;
        $display("FAIL rand_grant[%0d]: ready=%b, expected %b", cyc, req_ready, eg);
      end
      n_vec++;
      if ({mem_read_enable, mem_write_enable, mem_address, mem_write_data} !== edrv) begin
        n_err++;
        $display("FAIL rand_drive[%0d]: re=%b we=%b addr=%h wd=%h, expected %b %b %h %h", cyc,
                 mem_read_enable, mem_write_enable, mem_address, mem_write_data,
                 edrv[65], edrv[64], edrv[63:32], edrv[31:0]);
      end

      for (int p = 1; p < N; p++)
        wc[p] = (pv[p] && p != g) ? ((wc[p] < MAXW) ? wc[p] + 1 : MAXW) : 0;
      nrv = 1'b0;
      nrp = 0;
      nrd = '0;
      if (g >= 0) begin
        nrv = !pwe[g];
        nrp = g;
        nrd = sh[pa[g][4:2]];
        if (pwe[g]) sh[pa[g][4:2]] = pd[g];
        ptr   = (g + 1) % N;
        pv[g] = 1'b0;
      end

      @(posedge clk); #1;
      n_vec++;
      if (nrv ? (rsp_valid !== (N'(1) << nrp) || rsp_data !== nrd) : (rsp_valid !== 2'b00)) begin
        n_err++;
        $display("FAIL rand_rsp[%0d]: rsp_valid=%b data=%h, expected %b %h", cyc, rsp_valid, rsp_data,
                 nrv ? (N'(1) << nrp) : 2'b00, nrd);
      end
    end
    clear_req();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_read();
    test_write_read();
    test_contention();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
